// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a host payload of up to 63 bytes, then sends header, payload and an XOR parity byte to a router.
// Optional feature: define PARITY_INJECT_EN to add the corrupt port, which inverts the transmitted parity byte.
module router_pkt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] len,
    input  logic [1:0] addr,
    output logic       ready,
    output logic       reject,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       busy,
    output logic [7:0] din,
    output logic       pkt_valid,
    output logic       done
`ifdef PARITY_INJECT_EN
    ,
    input  logic       corrupt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY
    } state_t;

    state_t     state;
    logic [5:0] len_q;
    logic [1:0] addr_q;
    logic [5:0] idx;
    logic [7:0] parity;
    logic [7:0] parity_tx;
    logic [7:0] pbuf [63];

`ifdef PARITY_INJECT_EN
    logic corrupt_q;
    assign parity_tx = parity ^ {8{corrupt_q}};
`else
    assign parity_tx = parity;
`endif

    assign ready   = (state == IDLE);
    assign s_ready = (state == LOAD);

    // Payload storage is not reset; a reset simply abandons whatever it holds.
    always_ff @(posedge clk) begin
        if (state == LOAD && s_valid) begin
            pbuf[idx] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            idx       <= '0;
            parity    <= '0;
            din       <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
`ifdef PARITY_INJECT_EN
            corrupt_q <= 1'b0;
`endif
        end else begin
            reject <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == 6'd0 || addr == 2'd3) begin
                            reject <= 1'b1;
                        end else begin
                            len_q  <= len;
                            addr_q <= addr;
                            parity <= {len, addr};
                            idx    <= '0;
`ifdef PARITY_INJECT_EN
                            corrupt_q <= corrupt;
`endif
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        parity <= parity ^ s_data;
                        // Header goes out on the same edge that takes the last beat.
                        if (idx == len_q - 6'd1) begin
                            din       <= {len_q, addr_q};
                            pkt_valid <= 1'b1;
                            idx       <= '0;
                            state     <= HEADER;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        din   <= pbuf[0];
                        idx   <= 6'd1;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (idx < len_q) begin
                            din <= pbuf[idx];
                            idx <= idx + 6'd1;
                        end else begin
                            din       <= parity_tx;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        din   <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
